multicycle_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 32-bit stack processor: walks each instruction through FETCH/DECODE/EXEC/MEM/WB, owns the single shared memory port (instruction fetch vs. data access), and emits one-cycle strobes for PC, SP and register-file updates. It sits between the unified memory and the control-decode/datapath, replacing free-running per-clock decoding with an explicit state machine and a memory handshake.

---
 rtl/multicycle_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB and owns the shared memory port.
// Latency: start to first fetch request 1 cycle; 3-5 cycles per instruction plus one per memory wait cycle.
// Backpressure: mem_req held until mem_ack; MEM_TIMEOUT request cycles without ack raise bus_err and halt.
module multicycle_sequencer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        start_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic        mem_sel_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   input  logic [31:0] br_val_i,
   output logic [31:0] instr_o,
   output logic        pc_inc_o,
   output logic        pc_branch_o,
   output logic        pc_ret_o,
   output logic        sp_inc_o,
   output logic        sp_dec_o,
   output logic        reg_write_o,
   output logic        sp_write_o,
   output logic [2:0]  state_o,
   output logic        halted_o,
   output logic        illegal_o,
   output logic        bus_err_o
);

   // Wait counter only needs to reach MEM_TIMEOUT-1; the next ack-less cycle is the timeout.
   localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      instr_q, instr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   // Instruction decode from the instruction register
   logic [1:0] op_cls;
   logic [3:0] op_sub;
   logic       is_halt;
   logic       is_arith, is_push, is_pop, is_move, is_imm;
   logic       is_jump, is_bltz, is_bgtz, is_beqz;
   logic       is_load, is_store, is_lds, is_sts, is_call, is_ret;
   logic       is_alu, is_branch, is_memop, is_legal;
   logic       mem_write, mem_to_wb, br_taken, timeout_hit;

   assign op_cls   = instr_q[31:30];
   assign op_sub   = instr_q[29:26];
   assign is_halt  = (instr_q[31:26] == 6'h3F);

   assign is_arith = (op_cls == 2'd0) && (op_sub == 4'd0);
   assign is_push  = (op_cls == 2'd0) && (op_sub == 4'd1);
   assign is_pop   = (op_cls == 2'd0) && (op_sub == 4'd2);
   assign is_move  = (op_cls == 2'd0) && (op_sub == 4'd3);
   assign is_imm   = (op_cls == 2'd1);
   assign is_jump  = (op_cls == 2'd2) && (op_sub == 4'd0);
   assign is_bltz  = (op_cls == 2'd2) && (op_sub == 4'd1);
   assign is_bgtz  = (op_cls == 2'd2) && (op_sub == 4'd2);
   assign is_beqz  = (op_cls == 2'd2) && (op_sub == 4'd3);
   assign is_load  = (op_cls == 2'd3) && (op_sub == 4'd0);
   assign is_store = (op_cls == 2'd3) && (op_sub == 4'd1);
   assign is_lds   = (op_cls == 2'd3) && (op_sub == 4'd2);
   assign is_sts   = (op_cls == 2'd3) && (op_sub == 4'd3);
   assign is_call  = (op_cls == 2'd3) && (op_sub == 4'd4);
   assign is_ret   = (op_cls == 2'd3) && (op_sub == 4'd5);

   assign is_alu    = is_arith | is_imm | is_move;
   assign is_branch = is_jump | is_bltz | is_bgtz | is_beqz;
   assign is_memop  = is_push | is_pop | is_load | is_store | is_lds | is_sts | is_call | is_ret;
   assign is_legal  = is_alu | is_branch | is_memop;
   assign mem_write = is_store | is_sts | is_push | is_call;
   assign mem_to_wb = is_load | is_pop | is_lds | is_ret;

   assign br_taken = is_jump
                   | (is_bltz & br_val_i[31])
                   | (is_bgtz & ~br_val_i[31] & (br_val_i != 32'd0))
                   | (is_beqz & (br_val_i == 32'd0));

   assign timeout_hit = ~mem_ack_i && (cnt_q == CNT_LAST);

   // State register plus instruction/wait-counter/sticky flag storage
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q   <= S_IDLE;
         instr_q   <= 32'd0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   // Next-state logic; the wait counter is cleared on every entry to FETCH or MEM
   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end
         end
         S_FETCH: begin
            if (mem_ack_i) begin
               instr_d = mem_rdata_i;
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DECODE: begin
            if (is_halt) begin
               state_d = S_HALT;
            end else if (!is_legal) begin
               illegal_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_alu) begin
               state_d = S_WB;
            end else if (is_branch) begin
               state_d = S_FETCH;
               cnt_d   = '0;
            end else begin
               state_d = S_MEM;
               cnt_d   = '0;
            end
         end
         S_MEM: begin
            if (mem_ack_i) begin
               if (mem_to_wb) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  cnt_d   = '0;
               end
            end else if (timeout_hit) begin
               bus_err_d = 1'b1;
               state_d   = S_HALT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            cnt_d   = '0;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from registered state; MEM strobes are additionally qualified by mem_ack
   always_comb begin
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_sel_o   = 1'b0;
      pc_inc_o    = 1'b0;
      pc_branch_o = 1'b0;
      pc_ret_o    = 1'b0;
      sp_inc_o    = 1'b0;
      sp_dec_o    = 1'b0;
      reg_write_o = 1'b0;
      sp_write_o  = 1'b0;
      halted_o    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_o = 1'b1;
         end
         S_EXEC: begin
            if (is_branch) begin
               pc_branch_o = br_taken;
               pc_inc_o    = ~br_taken;
            end
         end
         S_MEM: begin
            mem_req_o = 1'b1;
            mem_sel_o = 1'b1;
            mem_we_o  = mem_write;
            if (mem_ack_i) begin
               sp_dec_o    = is_push | is_call;
               sp_inc_o    = is_pop | is_ret;
               pc_inc_o    = is_store | is_sts | is_push;
               pc_branch_o = is_call;
            end
         end
         S_WB: begin
            reg_write_o = is_alu | is_load | is_pop;
            sp_write_o  = is_lds;
            pc_ret_o    = is_ret;
            pc_inc_o    = ~is_ret;
         end
         S_HALT: begin
            halted_o = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign instr_o   = instr_q;
   assign state_o   = state_q;
   assign illegal_o = illegal_q;
   assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream with a per-instruction reference model and scoreboard.
// Latency: model predicts cycles, strobes and memory request counts for each retired instruction.
// Backpressure: memory responder inserts random ack wait states; timeout and reset-abort handled directly.
module tb_multicycle_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, mem_ack;
   logic [31:0] mem_rdata, br_val;
   logic        mem_req, mem_we, mem_sel;
   logic [31:0] instr;
   logic        pc_inc, pc_branch, pc_ret, sp_inc, sp_dec, reg_write, sp_write;
   logic [2:0]  state;
   logic        halted, illegal, bus_err;

   always #5 clk = ~clk;

   multicycle_sequencer #(.MEM_TIMEOUT(16)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_sel_o   (mem_sel),
      .mem_ack_i   (mem_ack),
      .mem_rdata_i (mem_rdata),
      .br_val_i    (br_val),
      .instr_o     (instr),
      .pc_inc_o    (pc_inc),
      .pc_branch_o (pc_branch),
      .pc_ret_o    (pc_ret),
      .sp_inc_o    (sp_inc),
      .sp_dec_o    (sp_dec),
      .reg_write_o (reg_write),
      .sp_write_o  (sp_write),
      .state_o     (state),
      .halted_o    (halted),
      .illegal_o   (illegal),
      .bus_err_o   (bus_err)
   );

   // Expected behaviour of one instruction, from fetch request to its PC strobe
   typedef struct {
      logic [31:0] ins;
      int          cyc;
      logic [2:0]  pc;     // {ret, branch, inc}
      int          spi, spd, rw, spw, ireq, dreq, dwe;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   a_cyc, a_spi, a_spd, a_rw, a_spw, a_ireq, a_dreq, a_dwe;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, want, $time);
      end
   endfunction

   // Reference model: cycle cost and side effects by instruction kind
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] bv,
                                  input int wf, input int wm);
      exp_t e;
      int   c, s;
      logic taken;
      c = int'(ins[31:30]);
      s = int'(ins[29:26]);
      e.ins = ins; e.cyc = 0; e.pc = 3'b001;
      e.spi = 0; e.spd = 0; e.rw = 0; e.spw = 0;
      e.ireq = wf + 1; e.dreq = 0; e.dwe = 0;
      if (c == 1 || (c == 0 && (s == 0 || s == 3))) begin
         e.cyc = 4 + wf;
         e.rw  = 1;
      end else if (c == 2) begin
         case (s)
            0:       taken = 1'b1;
            1:       taken = ($signed(bv) < 0);
            2:       taken = ($signed(bv) > 0);
            default: taken = (bv == 32'd0);
         endcase
         e.cyc = 3 + wf;
         e.pc  = taken ? 3'b010 : 3'b001;
      end else begin
         e.dreq = wm + 1;
         if ((c == 0 && s == 1) || (c == 3 && (s == 1 || s == 3))) begin
            e.cyc = 4 + wf + wm;
            e.dwe = wm + 1;
            e.spd = (c == 0) ? 1 : 0;
         end else if (c == 3 && s == 4) begin
            e.cyc = 4 + wf + wm;
            e.dwe = wm + 1;
            e.spd = 1;
            e.pc  = 3'b010;
         end else if (c == 3 && s == 5) begin
            e.cyc = 5 + wf + wm;
            e.spi = 1;
            e.pc  = 3'b100;
         end else begin
            e.cyc = 5 + wf + wm;
            e.spw = (c == 3 && s == 2) ? 1 : 0;
            e.rw  = (c == 3 && s == 2) ? 0 : 1;
            e.spi = (c == 0) ? 1 : 0;
         end
      end
      return e;
   endfunction

   // Monitor: accumulate strobes per instruction and score at each PC strobe
   always @(negedge clk) begin
      if (reset || state == 3'd0 || halted) begin
         a_cyc = 0; a_spi = 0; a_spd = 0; a_rw = 0; a_spw = 0; a_ireq = 0; a_dreq = 0; a_dwe = 0;
      end else begin
         a_cyc++;
         if (mem_req && !mem_sel) a_ireq++;
         if (mem_req && mem_sel)  a_dreq++;
         if (mem_req && mem_we)   a_dwe++;
         if (sp_inc)    a_spi++;
         if (sp_dec)    a_spd++;
         if (reg_write) a_rw++;
         if (sp_write)  a_spw++;
         if (pc_inc || pc_branch || pc_ret) begin
            chk("pc_onehot", $countones({pc_ret, pc_branch, pc_inc}), 32'd1);
            chk("retire_expected", exp_q.size(), exp_q.size() == 0 ? 32'd1 : exp_q.size());
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               chk("instr_reg", instr, mon_e.ins);
               chk("pc_kind", 32'({pc_ret, pc_branch, pc_inc}), 32'(mon_e.pc));
               chk("cycles", a_cyc, mon_e.cyc);
               chk("fetch_req_cycles", a_ireq, mon_e.ireq);
               chk("data_req_cycles", a_dreq, mon_e.dreq);
               chk("write_cycles", a_dwe, mon_e.dwe);
               chk("sp_inc_count", a_spi, mon_e.spi);
               chk("sp_dec_count", a_spd, mon_e.spd);
               chk("reg_write_count", a_rw, mon_e.rw);
               chk("sp_write_count", a_spw, mon_e.spw);
            end
            a_cyc = 0; a_spi = 0; a_spd = 0; a_rw = 0; a_spw = 0; a_ireq = 0; a_dreq = 0; a_dwe = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Memory responder: wait for a request, hold ack low for 'waits' cycles, then ack once
   task automatic serve(input logic [31:0] rd, input int waits);
      int n;
      n = 0;
      while (!mem_req && n < 50) begin
         tick();
         n++;
      end
      chk("serve_req_seen", 32'(mem_req), 32'd1);
      if (!mem_req) return;
      repeat (waits) begin
         mem_ack = 1'b0;
         tick();
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic [31:0] bv, input int wf, input int wm);
      exp_t e;
      e = model(ins, bv, wf, wm);
      exp_q.push_back(e);
      serve(ins, wf);
      br_val = bv;              // now in DECODE; held through EXEC
      if (e.dreq > 0) serve($urandom, wm);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      start   = 1'b0;
      mem_ack = 1'b0;
      exp_q.delete();
      tick();
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick();
         n++;
      end
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   function automatic int rand_wait();
      return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [1:0]  c;
      logic [3:0]  s;
      logic [31:0] ins, bv;
      int          n;

      reset = 1'b1; start = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0; br_val = 32'd0;
      tick();
      tick();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_outputs", 32'({mem_req, mem_we, mem_sel, pc_inc, pc_branch, pc_ret,
                              sp_inc, sp_dec, reg_write, sp_write}), 32'd0);
      chk("rst_flags", 32'({halted, illegal, bus_err}), 32'd0);
      reset = 1'b0;
      tick();
      tick();
      chk("idle_hold", 32'(state), 32'd0);
      go();
      chk("start_to_fetch", 32'(state), 32'd1);
      chk("start_fetch_req", 32'(mem_req), 32'd1);

      // Arith 0x00000300, zero wait: states 1,2,3,5,1
      exp_q.push_back(model(32'h0000_0300, 32'd0, 0, 0));
      mem_ack = 1'b1; mem_rdata = 32'h0000_0300;
      tick();
      mem_ack = 1'b0;
      chk("arith_decode", 32'(state), 32'd2);
      tick();
      chk("arith_exec", 32'(state), 32'd3);
      chk("arith_exec_rw", 32'({reg_write, pc_inc}), 32'd0);
      tick();
      chk("arith_wb", 32'(state), 32'd5);
      chk("arith_wb_rw", 32'({reg_write, pc_inc}), 32'd3);
      tick();
      chk("arith_refetch", 32'(state), 32'd1);
      chk("arith_refetch_rw", 32'({reg_write, pc_inc}), 32'd0);

      // Directed branches, push with wait states, ret
      run_instr(32'h8400_0000, 32'hFFFF_FFFB, 0, 0);   // bltz, -5: taken
      run_instr(32'h8400_0000, 32'h0000_0000, 0, 0);   // bltz, 0: not taken
      run_instr(32'h8C00_0000, 32'h0000_0000, 1, 0);   // beqz, 0: taken
      run_instr(32'h8800_0000, 32'h0000_0000, 0, 0);   // bgtz, 0: not taken
      run_instr(32'h8800_0000, 32'h8000_0000, 0, 0);   // bgtz, most negative: not taken
      run_instr(32'h0400_0000, 32'd0, 0, 2);           // push, 3 request cycles
      run_instr(32'hD400_0000, 32'd0, 0, 1);           // ret

      // Random legal instruction stream
      for (int i = 0; i < 150; i++) begin
         c = 2'($urandom_range(0, 3));
         case (c)
            2'd1:    s = 4'($urandom_range(0, 15));
            2'd3:    s = 4'($urandom_range(0, 5));
            default: s = 4'($urandom_range(0, 3));
         endcase
         ins = {c, s, 26'($urandom)};
         case ($urandom_range(0, 4))
            0:       bv = 32'd0;
            1:       bv = $urandom | 32'h8000_0000;
            2:       bv = ($urandom & 32'h7FFF_FFFF) | 32'd1;
            3:       bv = 32'd1;
            default: bv = $urandom;
         endcase
         run_instr(ins, bv, rand_wait(), rand_wait());
      end
      drain();

      // Reset while a store is waiting in MEM
      do_reset();
      go();
      serve(32'hC400_0000, 0);
      n = 0;
      while (!(mem_req && mem_sel) && n < 10) begin
         tick();
         n++;
      end
      chk("store_in_mem", 32'({mem_req, mem_sel, mem_we}), 32'd7);
      #2;
      reset = 1'b1;
      #1;
      chk("midmem_rst_req", 32'({mem_req, mem_we, mem_sel}), 32'd0);
      chk("midmem_rst_state", 32'(state), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      go();
      chk("post_rst_start", 32'(state), 32'd1);

      // Illegal opcode: class 3, sub 7
      serve(32'hDC00_0000, 0);
      tick();
      chk("illegal_state", 32'(state), 32'd6);
      chk("illegal_flags", 32'({halted, illegal, bus_err}), 32'b110);
      chk("illegal_req", 32'(mem_req), 32'd0);
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      chk("illegal_start_ignored", 32'(state), 32'd6);

      // Bus error: no ack at all on a fetch
      do_reset();
      chk("rst_clears_illegal", 32'(illegal), 32'd0);
      go();
      n = 0;
      while (mem_req && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_req_cycles", n, 32'd16);
      chk("timeout_state", 32'(state), 32'd6);
      chk("timeout_flags", 32'({halted, illegal, bus_err}), 32'b101);
      start = 1'b1; mem_ack = 1'b1;
      tick();
      start = 1'b0; mem_ack = 1'b0;
      chk("timeout_start_ignored", 32'({state, mem_req}), 32'b1100);

      // HALT opcode
      do_reset();
      chk("rst_clears_bus_err", 32'(bus_err), 32'd0);
      go();
      serve(32'hFC00_0123, 0);
      tick();
      chk("halt_state", 32'(state), 32'd6);
      chk("halt_flags", 32'({halted, illegal, bus_err}), 32'b100);
      chk("halt_instr", instr, 32'hFC00_0123);

      chk("queue_empty_end", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
